// File: rtl/pipe_hazard_unit.sv
// Hazard/forwarding controller: in-flight destination scoreboard, operand forwarding, load-use stall, branch flush.
// Optional perf counters (stall_cnt/flush_cnt) are built when HAZ_PERF_CNT_EN is defined.

module pipe_hazard_src #(
   parameter int DATA_W     = 24,
   parameter int RADDR_W    = 4,
   parameter int NSTAGES    = 3,
   parameter int LOAD_STAGE = 2,
   parameter int SEL_W      = 2
) (
   input  logic [NSTAGES-1:0]              sbVld,
   input  logic [NSTAGES-1:0][RADDR_W-1:0] sbRd,
   input  logic [NSTAGES-1:0]              sbLoad,
   input  logic [RADDR_W-1:0]              src,
   input  logic                            srcUse,
   input  logic [DATA_W-1:0]               rfData,
   input  logic [NSTAGES-1:0][DATA_W-1:0]  stageRes,
   output logic [DATA_W-1:0]               op,
   output logic [SEL_W-1:0]                sel,
   output logic                            notReady
);
   // Scan oldest to youngest so the youngest matching entry has the last word.
   always_comb begin
      op       = rfData;
      sel      = '0;
      notReady = 1'b0;
      for (int k = NSTAGES - 1; k >= 0; k--) begin
         if (srcUse && sbVld[k] && (sbRd[k] == src)) begin
            if (!sbLoad[k] || (k >= LOAD_STAGE)) begin
               op       = stageRes[k];
               sel      = SEL_W'(k + 1);
               notReady = 1'b0;
            end else begin
               op       = rfData;
               sel      = '0;
               notReady = 1'b1;
            end
         end
      end
   end
endmodule

module pipe_hazard_unit #(
   parameter int DATA_W     = 24,
   parameter int RADDR_W    = 4,
   parameter int NSTAGES    = 3,
   parameter int LOAD_STAGE = 2,
   parameter int CNT_W      = 32,
   localparam int SEL_W     = $clog2(NSTAGES + 1)
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        dec_valid,
   input  logic [RADDR_W-1:0]          dec_rs1,
   input  logic [RADDR_W-1:0]          dec_rs2,
   input  logic                        dec_rs1_use,
   input  logic                        dec_rs2_use,
   input  logic [RADDR_W-1:0]          dec_rd,
   input  logic                        dec_rd_we,
   input  logic                        dec_is_load,
   input  logic [DATA_W-1:0]           rf_rd1,
   input  logic [DATA_W-1:0]           rf_rd2,
   input  logic [NSTAGES*DATA_W-1:0]   stage_res,
   input  logic                        ex_branch_taken,
   output logic [DATA_W-1:0]           op1,
   output logic [DATA_W-1:0]           op2,
   output logic [SEL_W-1:0]            fwd_sel1,
   output logic [SEL_W-1:0]            fwd_sel2,
   output logic                        stall,
   output logic                        flush,
   output logic                        ex_bubble
`ifdef HAZ_PERF_CNT_EN
   ,
   output logic [CNT_W-1:0]            stall_cnt,
   output logic [CNT_W-1:0]            flush_cnt
`endif
);
   if (NSTAGES < 2) begin : gBadStages
      $error("NSTAGES must be at least 2");
   end
   if ((LOAD_STAGE < 1) || (LOAD_STAGE > NSTAGES - 1)) begin : gBadLoad
      $error("LOAD_STAGE out of range");
   end

   logic [NSTAGES-1:0]              sbVld;
   logic [NSTAGES-1:0][RADDR_W-1:0] sbRd;
   logic [NSTAGES-1:0]              sbLoad;
   logic [NSTAGES-1:0][DATA_W-1:0]  stageRes;

   logic [1:0][RADDR_W-1:0] srcAddr;
   logic [1:0]              srcUse;
   logic [1:0][DATA_W-1:0]  rfData;
   logic [1:0][DATA_W-1:0]  opRes;
   logic [1:0][SEL_W-1:0]   selRes;
   logic [1:0]              notReady;
   logic                    issue;

   assign stageRes = stage_res;
   assign srcAddr  = {dec_rs2, dec_rs1};
   assign srcUse   = {dec_rs2_use, dec_rs1_use};
   assign rfData   = {rf_rd2, rf_rd1};

   for (genvar s = 0; s < 2; s++) begin : gSrc
      pipe_hazard_src #(
         .DATA_W(DATA_W), .RADDR_W(RADDR_W), .NSTAGES(NSTAGES),
         .LOAD_STAGE(LOAD_STAGE), .SEL_W(SEL_W)
      ) uSrc (
         .sbVld(sbVld), .sbRd(sbRd), .sbLoad(sbLoad),
         .src(srcAddr[s]), .srcUse(srcUse[s]), .rfData(rfData[s]),
         .stageRes(stageRes), .op(opRes[s]), .sel(selRes[s]), .notReady(notReady[s])
      );
   end

   assign op1       = opRes[0];
   assign op2       = opRes[1];
   assign fwd_sel1  = selRes[0];
   assign fwd_sel2  = selRes[1];
   assign flush     = ex_branch_taken;
   assign stall     = dec_valid & ~flush & (|notReady);
   assign ex_bubble = stall | flush | ~dec_valid;
   assign issue     = dec_valid & ~stall & ~flush;

   // Entries past EX keep advancing during stall/flush; only entry 0 takes a bubble.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sbVld  <= '0;
         sbRd   <= '0;
         sbLoad <= '0;
      end else begin
         sbVld[0]  <= issue & dec_rd_we;
         sbRd[0]   <= dec_rd;
         sbLoad[0] <= dec_is_load;
         for (int k = 1; k < NSTAGES; k++) begin
            sbVld[k]  <= sbVld[k-1];
            sbRd[k]   <= sbRd[k-1];
            sbLoad[k] <= sbLoad[k-1];
         end
      end
   end

`ifdef HAZ_PERF_CNT_EN
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         if (stall && !(&stall_cnt)) stall_cnt <= stall_cnt + 1'b1;
         if (flush && !(&flush_cnt)) flush_cnt <= flush_cnt + 1'b1;
      end
   end
`else
   if (CNT_W < 1) begin : gBadCnt
      $error("CNT_W must be positive");
   end
`endif
endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Randomized bench for pipe_hazard_unit against an issue-history model, plus directed literal checks.
module tb_pipe_hazard_unit;
   localparam int DATA_W = 24, RADDR_W = 4, NSTAGES = 3, LOAD_STAGE = 2, SEL_W = 2, CNT_W = 32;

   logic clk = 1'b0, reset = 1'b0;
   logic dec_valid, dec_rs1_use, dec_rs2_use, dec_rd_we, dec_is_load, ex_branch_taken;
   logic [RADDR_W-1:0] dec_rs1, dec_rs2, dec_rd;
   logic [DATA_W-1:0]  rf_rd1, rf_rd2, op1, op2;
   logic [NSTAGES-1:0][DATA_W-1:0] sr;
   logic [NSTAGES*DATA_W-1:0] stage_res;
   logic [SEL_W-1:0] fwd_sel1, fwd_sel2;
   logic stall, flush, ex_bubble;
`ifdef HAZ_PERF_CNT_EN
   logic [CNT_W-1:0] stall_cnt, flush_cnt;
`endif

   assign stage_res = sr;

   pipe_hazard_unit #(.DATA_W(DATA_W), .RADDR_W(RADDR_W), .NSTAGES(NSTAGES),
                      .LOAD_STAGE(LOAD_STAGE), .CNT_W(CNT_W)) dut (
      .clk(clk), .reset(reset), .dec_valid(dec_valid),
      .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_rs1_use(dec_rs1_use), .dec_rs2_use(dec_rs2_use),
      .dec_rd(dec_rd), .dec_rd_we(dec_rd_we), .dec_is_load(dec_is_load),
      .rf_rd1(rf_rd1), .rf_rd2(rf_rd2), .stage_res(stage_res), .ex_branch_taken(ex_branch_taken),
      .op1(op1), .op2(op2), .fwd_sel1(fwd_sel1), .fwd_sel2(fwd_sel2),
      .stall(stall), .flush(flush), .ex_bubble(ex_bubble)
`ifdef HAZ_PERF_CNT_EN
      , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
   );

   always #5 clk = ~clk;

   int nChecks = 0, nErr = 0;
   bit chkEn = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      nChecks++;
      if (act !== exp) begin
         nErr++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Model: list of issued register writers tagged with issue cycle; age 0 = EX.
   typedef struct { int cyc; logic [RADDR_W-1:0] rd; bit ld; } rec_t;
   rec_t q[$];
   int cyc = 0;
   longint mStallCnt = 0, mFlushCnt = 0;

   function automatic void resolveSrc(input logic [RADDR_W-1:0] s, input bit rd, input logic [DATA_W-1:0] rf,
                                      output logic [DATA_W-1:0] op, output int sel, output bit nr);
      int best = -1;
      bit bestLd = 0;
      op = rf; sel = 0; nr = 0;
      if (rd) begin
         foreach (q[i]) begin
            int age = cyc - q[i].cyc - 1;
            if (age >= 0 && age < NSTAGES && q[i].rd == s && (best < 0 || age < best)) begin
               best = age; bestLd = q[i].ld;
            end
         end
      end
      if (best >= 0) begin
         if (!bestLd || best >= LOAD_STAGE) begin
            op = sr[best]; sel = best + 1;
         end else nr = 1;
      end
   endfunction

   function automatic void modelEval(output logic [DATA_W-1:0] o1, output logic [DATA_W-1:0] o2,
                                     output int s1, output int s2, output bit st, output bit fl);
      bit nr1, nr2;
      resolveSrc(dec_rs1, dec_rs1_use, rf_rd1, o1, s1, nr1);
      resolveSrc(dec_rs2, dec_rs2_use, rf_rd2, o2, s2, nr2);
      fl = ex_branch_taken;
      st = dec_valid && !fl && (nr1 || nr2);
   endfunction

   always @(posedge clk or negedge reset) begin
      logic [DATA_W-1:0] o1, o2;
      int s1, s2;
      bit st, fl;
      if (!reset) begin
         q.delete(); mStallCnt = 0; mFlushCnt = 0;
      end else begin
         modelEval(o1, o2, s1, s2, st, fl);
         if (dec_valid && !st && !fl && dec_rd_we) q.push_back('{cyc, dec_rd, dec_is_load});
         if (st) mStallCnt++;
         if (fl) mFlushCnt++;
         cyc++;
         while (q.size() > 0 && (cyc - q[0].cyc - 1) >= NSTAGES) void'(q.pop_front());
      end
   end

   always @(negedge clk) begin
      logic [DATA_W-1:0] o1, o2;
      int s1, s2;
      bit st, fl;
      if (chkEn) begin
         modelEval(o1, o2, s1, s2, st, fl);
         chk("op1", op1, o1);
         chk("op2", op2, o2);
         chk("fwd_sel1", fwd_sel1, s1);
         chk("fwd_sel2", fwd_sel2, s2);
         chk("stall", stall, st);
         chk("flush", flush, fl);
         chk("ex_bubble", ex_bubble, st || fl || !dec_valid);
`ifdef HAZ_PERF_CNT_EN
         chk("stall_cnt", stall_cnt, mStallCnt);
         chk("flush_cnt", flush_cnt, mFlushCnt);
`endif
      end
   end

   task automatic drive(input bit v, input int rs1, input bit u1, input int rs2, input bit u2,
                        input int rd, input bit we, input bit ld, input bit br);
      dec_valid = v; dec_rs1 = RADDR_W'(rs1); dec_rs1_use = u1; dec_rs2 = RADDR_W'(rs2); dec_rs2_use = u2;
      dec_rd = RADDR_W'(rd); dec_rd_we = we; dec_is_load = ld; ex_branch_taken = br;
      rf_rd1 = DATA_W'($urandom); rf_rd2 = DATA_W'($urandom);
      for (int k = 0; k < NSTAGES; k++) sr[k] = DATA_W'($urandom);
   endtask

   // Advance one cycle, apply inputs just after the edge, settle before checking.
   task automatic step(input bit v, input int rs1, input bit u1, input int rs2, input bit u2,
                       input int rd, input bit we, input bit ld, input bit br);
      @(posedge clk); #1;
      drive(v, rs1, u1, rs2, u2, rd, we, ld, br);
      #3;
   endtask

   initial begin
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      #3;
      chk("reset stall", stall, 0);
      chk("reset fwd_sel1", fwd_sel1, 0);
      chk("reset op1", op1, rf_rd1);
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;
      chkEn = 1;

      // ALU chain
      step(1, 0, 0, 0, 0, 3, 1, 0, 0);
      step(1, 3, 1, 0, 0, 0, 0, 0, 0);
      chk("chain fwd_sel1", fwd_sel1, 1);
      chk("chain op1", op1, sr[0]);
      chk("chain stall", stall, 0);

      // Load-use with two stall cycles
      step(1, 0, 0, 0, 0, 5, 1, 1, 0);
      step(1, 5, 1, 0, 0, 0, 0, 0, 0);
      chk("ldu stall c1", stall, 1);
      chk("ldu bubble c1", ex_bubble, 1);
      step(1, 5, 1, 0, 0, 0, 0, 0, 0);
      chk("ldu stall c2", stall, 1);
      step(1, 5, 1, 0, 0, 0, 0, 0, 0);
      chk("ldu stall c3", stall, 0);
      chk("ldu fwd_sel1", fwd_sel1, 3);
      chk("ldu op1", op1, sr[2]);

      // Youngest of two writers wins
      step(1, 0, 0, 0, 0, 2, 1, 0, 0);
      step(1, 0, 0, 0, 0, 8, 1, 0, 0);
      step(1, 0, 0, 0, 0, 2, 1, 0, 0);
      step(1, 2, 1, 0, 0, 0, 0, 0, 0);
      chk("young fwd_sel1", fwd_sel1, 1);
      chk("young op1", op1, sr[0]);

      // Unused rs2 never stalls
      step(1, 0, 0, 0, 0, 6, 1, 1, 0);
      step(1, 1, 0, 6, 0, 0, 0, 0, 0);
      chk("nouse stall", stall, 0);
      chk("nouse fwd_sel2", fwd_sel2, 0);
      chk("nouse op2", op2, rf_rd2);

      // Branch during load-use stall; the flushed decode writer must not enter the scoreboard
      step(1, 0, 0, 0, 0, 7, 1, 1, 0);
      step(1, 7, 1, 0, 0, 9, 1, 0, 0);
      chk("br stall pre", stall, 1);
      step(1, 7, 1, 0, 0, 9, 1, 0, 1);
      chk("br flush", flush, 1);
      chk("br stall", stall, 0);
      chk("br bubble", ex_bubble, 1);
      step(1, 9, 1, 0, 0, 0, 0, 0, 0);
      chk("br no match", fwd_sel1, 0);
      chk("br after stall", stall, 0);

      // Random traffic with occasional async reset pulses
      for (int n = 0; n < 3000; n++) begin
         @(posedge clk); #1;
         if ($urandom_range(0, 1) == 0 || !stall)
            drive($urandom_range(0, 9) != 0, $urandom_range(0, 3), $urandom_range(0, 3) != 0,
                  $urandom_range(0, 3), $urandom_range(0, 3) != 0, $urandom_range(0, 3),
                  $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, $urandom_range(0, 9) == 0);
         else
            for (int k = 0; k < NSTAGES; k++) sr[k] = DATA_W'($urandom);
         if ($urandom_range(0, 199) == 0) begin
            #1 reset = 1'b0;
            #1 reset = 1'b1;
         end
      end

      // Reset in the middle of a load-use stall
      step(1, 0, 0, 0, 0, 4, 1, 1, 0);
      step(1, 4, 1, 0, 0, 0, 0, 0, 0);
      chk("rst pre stall", stall, 1);
      reset = 1'b0;
      #1;
      chk("rst stall", stall, 0);
      chk("rst fwd_sel1", fwd_sel1, 0);
      chk("rst op1", op1, rf_rd1);
      chk("rst flush", flush, 0);
`ifdef HAZ_PERF_CNT_EN
      chk("rst stall_cnt", stall_cnt, 0);
      chk("rst flush_cnt", flush_cnt, 0);
`endif
      @(posedge clk); #1 reset = 1'b1;
      step(1, 4, 1, 0, 0, 0, 0, 0, 0);
      chk("post rst stall", stall, 0);
      repeat (2) @(posedge clk);
      chkEn = 0;
      $display("Simulation finished: %0d checks, %0d errors", nChecks, nErr);
      $finish;
   end
endmodule
